// File: rtl/cmd_fetch_pkg.sv
// Shared types for the command fetch stage.
package cmd_fetch_pkg;

    // Fetch FSM: wait, issue reads, wait for last read data, hold command.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2,
        StValid = 2'd3
    } cmd_fetch_state_t;

endpackage

// File: rtl/cmd_fetch_if.sv
// Core-side request/handshake and memory-side read bus of the command fetch stage.
interface cmd_fetch_if #(
    parameter int unsigned CMD_ADDR_WIDTH = 8,
    parameter int unsigned MEM_WIDTH      = 32,
    parameter int unsigned MEM_TO_CMD     = 4
);
    localparam int unsigned CMD_WIDTH      = MEM_WIDTH * MEM_TO_CMD;
    localparam int unsigned MEM_ADDR_WIDTH = CMD_ADDR_WIDTH + $clog2(MEM_TO_CMD);

    // Core request side
    logic                      fetch_req;
    logic [CMD_ADDR_WIDTH-1:0] fetch_addr;
    logic                      flush;
    logic                      fetch_busy;
    // Memory side
    logic                      mem_en;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]      mem_data;
    // Command handshake side
    logic [CMD_WIDTH-1:0]      cmd_out;
    logic [CMD_ADDR_WIDTH-1:0] cmd_addr;
    logic                      cmd_valid;
    logic                      cmd_ready;

    // Fetch stage view
    modport master (
        input  fetch_req, fetch_addr, flush, mem_data, cmd_ready,
        output fetch_busy, mem_en, mem_addr, cmd_out, cmd_addr, cmd_valid
    );

    // Core plus memory view
    modport slave (
        output fetch_req, fetch_addr, flush, mem_data, cmd_ready,
        input  fetch_busy, mem_en, mem_addr, cmd_out, cmd_addr, cmd_valid
    );

endinterface

// File: rtl/cmd_word_assembler.sv
// Holds the assembled command; writes one memory word into its slot per enabled cycle.
module cmd_word_assembler #(
    parameter int unsigned MEM_WIDTH  = 32,
    parameter int unsigned MEM_TO_CMD = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                wr_en,
    input  logic [$clog2(MEM_TO_CMD)-1:0]       wr_idx,
    input  logic [MEM_WIDTH-1:0]                wr_word,
    output logic [MEM_WIDTH*MEM_TO_CMD-1:0]     cmd_out
);
    localparam int unsigned CMD_WIDTH = MEM_WIDTH * MEM_TO_CMD;
    localparam int unsigned IDX_WIDTH = $clog2(MEM_TO_CMD);

    logic [CMD_WIDTH-1:0] cmd_d, cmd_q;

    // Replace only the addressed slot; other slots keep their value.
    always_comb begin
        cmd_d = cmd_q;
        for (int i = 0; i < int'(MEM_TO_CMD); i++) begin
            if (wr_en && (wr_idx == IDX_WIDTH'(i))) begin
                cmd_d[MEM_WIDTH*i +: MEM_WIDTH] = wr_word;
            end
        end
    end

    // Command register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign cmd_out = cmd_q;

endmodule

// File: rtl/cmd_fetch.sv
// Command fetch stage: reads MEM_TO_CMD narrow memory words per command address and
// presents the assembled command to the core with a valid/ready handshake.
// MEM_TO_CMD must be a power of two and at least 2.
module cmd_fetch
    import cmd_fetch_pkg::*;
#(
    parameter int unsigned CMD_ADDR_WIDTH = 8,
    parameter int unsigned MEM_WIDTH      = 32,
    parameter int unsigned MEM_TO_CMD     = 4
) (
    input logic        clk,
    input logic        rstn,
    cmd_fetch_if.master bus
);
    localparam int unsigned CMD_WIDTH      = MEM_WIDTH * MEM_TO_CMD;
    localparam int unsigned IDX_WIDTH      = $clog2(MEM_TO_CMD);
    localparam int unsigned MEM_ADDR_WIDTH = CMD_ADDR_WIDTH + IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(MEM_TO_CMD - 1);

    cmd_fetch_state_t          state_d, state_q;
    logic [IDX_WIDTH-1:0]      rd_idx_d, rd_idx_q;
    logic [CMD_ADDR_WIDTH-1:0] cmd_addr_d, cmd_addr_q;
    logic                      mem_en_d, mem_en_q;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_d, mem_addr_q;
    logic                      cmd_valid_d, cmd_valid_q;
    // Capture tracking: which slot the word on mem_data belongs to, and whether it is live.
    logic                      cap_vld_d, cap_vld_q;
    logic [IDX_WIDTH-1:0]      cap_idx_d, cap_idx_q;
    logic                      start;
    logic [IDX_WIDTH-1:0]      rd_idx_inc;
    logic [CMD_WIDTH-1:0]      cmd_word;

    assign rd_idx_inc = rd_idx_q + IDX_WIDTH'(1);

    // Next-state and registered-output logic; flush overrides everything, and a
    // request seen alongside flush (or a handshake) starts a new fetch immediately.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        cmd_addr_d  = cmd_addr_q;
        mem_en_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        start       = 1'b0;
        cap_vld_d   = mem_en_q && !bus.flush;
        cap_idx_d   = rd_idx_q;

        if (bus.flush) begin
            state_d = StIdle;
            start   = bus.fetch_req;
        end else begin
            unique case (state_q)
                StIdle: begin
                    start = bus.fetch_req;
                end
                StRead: begin
                    if (rd_idx_q == LastIdx) begin
                        state_d = StDrain;
                    end else begin
                        rd_idx_d   = rd_idx_inc;
                        mem_en_d   = 1'b1;
                        mem_addr_d = {cmd_addr_q, rd_idx_inc};
                    end
                end
                StDrain: begin
                    if (cap_vld_q && (cap_idx_q == LastIdx)) begin
                        state_d = StValid;
                    end
                end
                StValid: begin
                    if (bus.cmd_ready) begin
                        state_d = StIdle;
                        start   = bus.fetch_req;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (start) begin
            state_d    = StRead;
            cmd_addr_d = bus.fetch_addr;
            rd_idx_d   = '0;
            mem_en_d   = 1'b1;
            mem_addr_d = {bus.fetch_addr, {IDX_WIDTH{1'b0}}};
        end

        cmd_valid_d = (state_d == StValid);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            rd_idx_q    <= '0;
            cmd_addr_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            cmd_valid_q <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            cmd_addr_q  <= cmd_addr_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            cmd_valid_q <= cmd_valid_d;
            cap_vld_q   <= cap_vld_d;
            cap_idx_q   <= cap_idx_d;
        end
    end

    // Word arriving in a flush cycle is dropped as well.
    cmd_word_assembler #(
        .MEM_WIDTH  (MEM_WIDTH),
        .MEM_TO_CMD (MEM_TO_CMD)
    ) u_assembler (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (cap_vld_q && !bus.flush),
        .wr_idx  (cap_idx_q),
        .wr_word (bus.mem_data),
        .cmd_out (cmd_word)
    );

    assign bus.fetch_busy = (state_q != StIdle);
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.cmd_out    = cmd_word;
    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.cmd_valid  = cmd_valid_q;

endmodule

// File: doc/cmd_fetch.md
# cmd_fetch

Command fetch stage directly upstream of the command memory interface: takes a command-granular instruction pointer from the processor core, issues `MEM_TO_CMD` sequential reads to the narrow (`MEM_WIDTH`-bit) single-port command memory, and assembles the returned words into one `CMD_WIDTH`-bit command. The command is presented to the core with a valid/ready handshake. A flush input aborts an in-flight fetch, and can restart it at a new address on a jump.

## Interface
Parameters:
- `CMD_ADDR_WIDTH`, 8, width of the command-granular instruction pointer.
- `MEM_WIDTH`, 32, width of one memory word.
- `MEM_TO_CMD`, 4, memory words per command; must be a power of two, ≥2.
- `CMD_WIDTH` (localparam), `MEM_WIDTH*MEM_TO_CMD`.
- `MEM_ADDR_WIDTH` (localparam), `CMD_ADDR_WIDTH + $clog2(MEM_TO_CMD)`.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  request a command fetch at `fetch_addr`.
- `fetch_addr`  in  `CMD_ADDR_WIDTH`  command address (instruction pointer).
- `flush`  in  1  abort the current fetch and drop any pending command.
- `fetch_busy`  out  1  high when not in IDLE; requests are ignored while high, except with `flush`.
- `mem_en`  out  1  memory read enable (registered).
- `mem_addr`  out  `MEM_ADDR_WIDTH`  memory word address (registered).
- `mem_data`  in  `MEM_WIDTH`  read data, valid exactly 1 cycle after `mem_en`.
- `cmd_out`  out  `CMD_WIDTH`  assembled command; word i sits at bits `[MEM_WIDTH*i +: MEM_WIDTH]`.
- `cmd_addr`  out  `CMD_ADDR_WIDTH`  address of `cmd_out`.
- `cmd_valid`  out  1  command available.
- `cmd_ready`  in  1  core accepts the command.

## Operation
- States:
  - IDLE: waiting for a request.
  - READ: issuing reads; counter `rd_idx` runs 0..`MEM_TO_CMD`-1.
  - DRAIN: the last read is in flight.
  - VALID: `cmd_valid` is high.
- IDLE → READ: on `fetch_req`. Latch `fetch_addr` into `cmd_addr` and clear `rd_idx`.
- READ:
  - Drive `mem_en=1` and `mem_addr={cmd_addr, rd_idx}` for one cycle per word.
  - After `rd_idx` reaches `MEM_TO_CMD-1`, go to DRAIN.
- Capture: the data returned one cycle after each read is written into word slot i of `cmd_out`, tracked by a registered copy of `rd_idx` plus a valid flag.
- DRAIN → VALID: after the last word is captured.
- VALID → IDLE: on `cmd_valid && cmd_ready`. If `fetch_req` is also high that cycle, go straight to READ instead (back-to-back fetch).
- `flush` has the highest priority, in any state:
  - Next cycle `mem_en=0` and `cmd_valid=0`, and the state goes to IDLE.
  - Data from a read already in flight is discarded and not written to `cmd_out`.
  - If `fetch_req` is high in the same cycle, the new address is accepted and the state goes to READ (jump).
- `cmd_out` and `cmd_addr` hold their last value after consumption. `cmd_out` contents are only defined while `cmd_valid=1`.
- Address arithmetic: `mem_addr` is a concatenation with no carry, so command address all-ones reads word addresses up to `2^MEM_ADDR_WIDTH-1` with no wrap into address 0.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE. Outputs `mem_en`, `mem_addr`, `cmd_out`, `cmd_addr`, `cmd_valid`, `fetch_busy` all 0.
- A request accepted in cycle T produces:
  - `mem_en` high on cycles T+1 .. T+`MEM_TO_CMD`.
  - `mem_data` word i sampled at end of T+2+i.
  - `cmd_valid` high from cycle T+`MEM_TO_CMD`+2. Latency is 6 for the defaults.
- `fetch_busy` is combinational from state, so it rises in T+1.
- Handshake:
  - `cmd_valid` stays high with `cmd_out` stable until the `cmd_ready` cycle.
  - `cmd_ready` while `cmd_valid=0` has no effect.
- Back-to-back fetch: throughput is one command every `MEM_TO_CMD`+2 cycles.
- Reset mid-fetch: immediate return to IDLE; in-flight read data is ignored.

## Structure
- Package `cmd_fetch_pkg` holds the state enum `cmd_fetch_state_t` (IDLE, READ, DRAIN, VALID).
- Width relations are localparams computed inside the module from its parameters.
- Sub-module `cmd_word_assembler`:
  - Inputs: word, index, write-enable.
  - Holds the `CMD_WIDTH` register.
  - The FSM and address generation stay in `cmd_fetch`.

## Test plan
- Basic fetch: reset, `fetch_req` with `fetch_addr=0x05`, memory model returns `0x1000_0000+word_addr`.
  - `mem_addr` must be 0x14, 0x15, 0x16, 0x17.
  - `cmd_valid` at T+6 with `cmd_out=0x10000017_10000016_10000015_10000014`, `cmd_addr=0x05`.
- Backpressure: hold `cmd_ready=0` for 10 cycles → `cmd_valid` and `cmd_out` stable throughout. `cmd_ready=1` → `cmd_valid` drops next cycle.
- Back-to-back: `fetch_req` at 0x10 in the same cycle as the handshake of 0x0F → new reads start the next cycle, with no idle cycle.
- Flush mid-read: `flush` during the third read → `mem_en=0` next cycle, no `cmd_valid`, and the in-flight word must not corrupt a later fetch. Repeat with `flush` + `fetch_req` at 0x20: the fetch restarts at `mem_addr` 0x80.
- Boundary: `fetch_addr=0xFF` → `mem_addr` 0x3FC..0x3FF, with no wrap. `fetch_req` while busy is ignored.
- Async reset asserted in VALID → all outputs 0 immediately, and a fresh fetch works afterwards.
